// File: rtl/uart_rx_deserializer.sv
// UART receive path: 16x oversampled frame recovery with break, parity and frame checks.
// Frames are {start(0), data MSB-first, optional even parity, stop(1) x STOP_BITS}.
module uart_rx_deserializer #(
  parameter int unsigned SYSCLK_RATE = 100000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_BIT  = 1,
  parameter int unsigned STOP_BITS   = 2
) (
  input  logic                 SysClk,
  input  logic                 Rst,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Rdy,
  output logic [2:0]           Rx_Error,
  output logic                 Rx_Busy
);

  localparam int unsigned DIV    = SYSCLK_RATE / (BAUD_RATE * 16);
  localparam int unsigned TICK_W = $clog2(DIV);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BRKWT
  } state_t;

  state_t state, state_n;

  logic                 rx_meta, rx_sync, rx_prev;
  logic [TICK_W-1:0]    tick_cnt;
  logic [CNT_W-1:0]     sample_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 s7, s8;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 all_zero;
  logic                 frame_err;

  logic tick, fall, in_frame, decide, bit_val, par_err;

  assign tick     = (tick_cnt == TICK_W'(DIV - 1));
  assign fall     = rx_prev & ~rx_sync;
  assign in_frame = (state == S_START) || (state == S_DATA) ||
                    (state == S_PARITY) || (state == S_STOP);
  assign decide   = in_frame && tick && (sample_cnt == CNT_W'(9));
  // Majority of samples 7, 8 and the live sample 9
  assign bit_val  = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);
  assign par_err  = (PARITY_BIT != 0) && ((^shreg) ^ par_bit);

  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (fall) state_n = S_START;
      S_START:  if (decide) state_n = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (decide && (bit_cnt == CNT_W'(DATA_BITS - 1)))
                  state_n = (PARITY_BIT != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (decide) state_n = S_STOP;
      S_STOP:   if (decide && (bit_cnt == CNT_W'(STOP_BITS - 1))) state_n = S_DONE;
      S_DONE:   state_n = all_zero ? S_BRKWT : S_IDLE;
      S_BRKWT:  if (rx_sync) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      rx_meta    <= 1'b0;
      rx_sync    <= 1'b0;
      rx_prev    <= 1'b0;
      tick_cnt   <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      s7         <= 1'b0;
      s8         <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      all_zero   <= 1'b0;
      frame_err  <= 1'b0;
      Data_Out   <= '0;
      Data_Rdy   <= 1'b0;
      Rx_Error   <= '0;
      Rx_Busy    <= 1'b0;
    end else begin
      rx_meta  <= Rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      Rx_Busy  <= (state_n != S_IDLE);
      Data_Rdy <= 1'b0;

      // Counters idle at zero so every frame starts its timing from the start edge
      if (state == S_IDLE) begin
        tick_cnt   <= '0;
        sample_cnt <= '0;
      end else if (tick) begin
        tick_cnt   <= '0;
        sample_cnt <= sample_cnt + CNT_W'(1);
        if (sample_cnt == CNT_W'(7)) s7 <= rx_sync;
        if (sample_cnt == CNT_W'(8)) s8 <= rx_sync;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end

      if (state_n != state) bit_cnt <= '0;
      else if (decide)      bit_cnt <= bit_cnt + CNT_W'(1);

      if ((state == S_IDLE) && fall) begin
        all_zero  <= 1'b1;
        frame_err <= 1'b0;
        shreg     <= '0;
        par_bit   <= 1'b0;
      end

      if (decide) begin
        all_zero <= all_zero & ~bit_val;
        case (state)
          S_DATA:   shreg <= {shreg[DATA_BITS-2:0], bit_val};
          S_PARITY: par_bit <= bit_val;
          S_STOP:   if (!bit_val) frame_err <= 1'b1;
          default:  ;
        endcase
      end

      if (state == S_DONE) begin
        Data_Rdy <= 1'b1;
        Data_Out <= shreg;
        Rx_Error <= all_zero ? 3'b001 : {frame_err, par_err, 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at DIV=10 (160 SysClk cycles per bit).
module tb_uart_rx_deserializer;

  localparam int BIT_CYC = 160;

  logic       SysClk = 1'b0;
  logic       Rst;
  logic       Rx;
  logic [7:0] Data_Out;
  logic       Data_Rdy;
  logic [2:0] Rx_Error;
  logic       Rx_Busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_run = 0;
  int max_run = 0;
  logic [7:0] q_data[$];
  logic [2:0] q_err[$];
  int         q_cyc[$];

  uart_rx_deserializer #(
    .SYSCLK_RATE(1600000),
    .BAUD_RATE  (10000),
    .DATA_BITS  (8),
    .PARITY_BIT (1),
    .STOP_BITS  (2)
  ) dut (
    .SysClk  (SysClk),
    .Rst     (Rst),
    .Rx      (Rx),
    .Data_Out(Data_Out),
    .Data_Rdy(Data_Rdy),
    .Rx_Error(Rx_Error),
    .Rx_Busy (Rx_Busy)
  );

  always #5 SysClk = ~SysClk;

  always @(posedge SysClk) cyc <= cyc + 1;

  // Strobe log, sampled on the falling edge
  always @(negedge SysClk) begin
    if (Data_Rdy === 1'b1) begin
      q_data.push_back(Data_Out);
      q_err.push_back(Rx_Error);
      q_cyc.push_back(cyc);
      rdy_run = rdy_run + 1;
      if (rdy_run > max_run) max_run = rdy_run;
    end else begin
      rdy_run = 0;
    end
  end

  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (BIT_CYC) @(negedge SysClk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic [1:0] stops);
    drive_bit(1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stops[1]);
    drive_bit(stops[0]);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    Rx  = 1'b1;
    repeat (3) @(negedge SysClk);
    checks++; if (Data_Out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", Data_Out); end
    checks++; if (Data_Rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", Data_Rdy); end
    checks++; if (Rx_Error !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", Rx_Error); end
    checks++; if (Rx_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Rx_Busy); end
    Rst = 1'b0;
    repeat (200) @(negedge SysClk);
  endtask

  task automatic test_good_frame();
    int n0, c0;
    logic [7:0] gd;
    logic [2:0] ge;
    int lat;
    n0 = q_data.size();
    c0 = cyc;
    send_frame(8'hA5, 1'b0, 2'b11);
    gd  = (q_data.size() > n0) ? q_data[n0] : 8'hxx;
    ge  = (q_err.size() > n0) ? q_err[n0] : 3'bxxx;
    lat = (q_cyc.size() > n0) ? q_cyc[n0] - c0 : -1;
    checks++; if (q_data.size() !== n0 + 1) begin errors++; $display("FAIL good_count: got %0d expected %0d", q_data.size(), n0 + 1); end
    checks++; if (gd !== 8'hA5) begin errors++; $display("FAIL good_data: got %h expected a5", gd); end
    checks++; if (ge !== 3'b000) begin errors++; $display("FAIL good_err: got %b expected 000", ge); end
    // start edge to strobe: 11 bits + 102.5 cycles to last decision, +1 to DONE output
    checks++; if (lat !== 1864) begin errors++; $display("FAIL good_latency: got %0d expected 1864", lat); end
    repeat (100) @(negedge SysClk);
  endtask

  task automatic test_parity_error();
    int n0;
    logic [7:0] gd;
    logic [2:0] ge;
    n0 = q_data.size();
    send_frame(8'hAA, 1'b1, 2'b11);
    gd = (q_data.size() > n0) ? q_data[n0] : 8'hxx;
    ge = (q_err.size() > n0) ? q_err[n0] : 3'bxxx;
    checks++; if (q_data.size() !== n0 + 1) begin errors++; $display("FAIL par_count: got %0d expected %0d", q_data.size(), n0 + 1); end
    checks++; if (gd !== 8'hAA) begin errors++; $display("FAIL par_data: got %h expected aa", gd); end
    checks++; if (ge !== 3'b010) begin errors++; $display("FAIL par_err: got %b expected 010", ge); end
    repeat (100) @(negedge SysClk);
  endtask

  task automatic test_frame_error();
    int n0;
    logic [7:0] gd;
    logic [2:0] ge;
    n0 = q_data.size();
    send_frame(8'hAA, 1'b0, 2'b00);
    gd = (q_data.size() > n0) ? q_data[n0] : 8'hxx;
    ge = (q_err.size() > n0) ? q_err[n0] : 3'bxxx;
    checks++; if (q_data.size() !== n0 + 1) begin errors++; $display("FAIL frm_count: got %0d expected %0d", q_data.size(), n0 + 1); end
    checks++; if (gd !== 8'hAA) begin errors++; $display("FAIL frm_data: got %h expected aa", gd); end
    checks++; if (ge !== 3'b100) begin errors++; $display("FAIL frm_err: got %b expected 100", ge); end
    drive_bit(1'b1);
    n0 = q_data.size();
    send_frame(8'h3C, 1'b0, 2'b11);
    gd = (q_data.size() > n0) ? q_data[n0] : 8'hxx;
    ge = (q_err.size() > n0) ? q_err[n0] : 3'bxxx;
    checks++; if (q_data.size() !== n0 + 1) begin errors++; $display("FAIL after_frm_count: got %0d expected %0d", q_data.size(), n0 + 1); end
    checks++; if (gd !== 8'h3C) begin errors++; $display("FAIL after_frm_data: got %h expected 3c", gd); end
    checks++; if (ge !== 3'b000) begin errors++; $display("FAIL after_frm_err: got %b expected 000", ge); end
    repeat (100) @(negedge SysClk);
  endtask

  task automatic test_break();
    int n0;
    logic [7:0] gd;
    logic [2:0] ge;
    n0 = q_data.size();
    Rx = 1'b0;
    repeat (12 * BIT_CYC) @(negedge SysClk);
    gd = (q_data.size() > n0) ? q_data[n0] : 8'hxx;
    ge = (q_err.size() > n0) ? q_err[n0] : 3'bxxx;
    checks++; if (q_data.size() !== n0 + 1) begin errors++; $display("FAIL brk_count: got %0d expected %0d", q_data.size(), n0 + 1); end
    checks++; if (gd !== 8'h00) begin errors++; $display("FAIL brk_data: got %h expected 00", gd); end
    checks++; if (ge !== 3'b001) begin errors++; $display("FAIL brk_err: got %b expected 001", ge); end
    checks++; if (Rx_Busy !== 1'b1) begin errors++; $display("FAIL brk_busy_low: got %b expected 1", Rx_Busy); end
    Rx = 1'b1;
    repeat (10) @(negedge SysClk);
    checks++; if (Rx_Busy !== 1'b0) begin errors++; $display("FAIL brk_busy_high: got %b expected 0", Rx_Busy); end
    repeat (2 * BIT_CYC) @(negedge SysClk);
    checks++; if (q_data.size() !== n0 + 1) begin errors++; $display("FAIL brk_single: got %0d expected %0d", q_data.size(), n0 + 1); end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = q_data.size();
    Rx = 1'b0;
    repeat (20) @(negedge SysClk);
    checks++; if (Rx_Busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_on: got %b expected 1", Rx_Busy); end
    repeat (20) @(negedge SysClk);
    Rx = 1'b1;
    repeat (BIT_CYC - 40) @(negedge SysClk);
    checks++; if (Rx_Busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_off: got %b expected 0", Rx_Busy); end
    repeat (BIT_CYC) @(negedge SysClk);
    checks++; if (q_data.size() !== n0) begin errors++; $display("FAIL glitch_strobe: got %0d expected %0d", q_data.size(), n0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [7:0] vec[4];
    logic [7:0] gd;
    logic [2:0] ge;
    vec = '{8'h00, 8'hFF, 8'h55, 8'h81};
    n0 = q_data.size();
    for (int i = 0; i < 4; i++) send_frame(vec[i], 1'b0, 2'b11);
    checks++; if (q_data.size() !== n0 + 4) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", q_data.size(), n0 + 4); end
    for (int i = 0; i < 4; i++) begin
      gd = (q_data.size() > n0 + i) ? q_data[n0 + i] : 8'hxx;
      ge = (q_err.size() > n0 + i) ? q_err[n0 + i] : 3'bxxx;
      checks++; if (gd !== vec[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, gd, vec[i]); end
      checks++; if (ge !== 3'b000) begin errors++; $display("FAIL b2b_err%0d: got %b expected 000", i, ge); end
    end
    repeat (100) @(negedge SysClk);
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    logic [7:0] gd;
    logic [2:0] ge;
    n0 = q_data.size();
    Rx = 1'b0;
    repeat (3 * BIT_CYC) @(negedge SysClk);
    Rst = 1'b1;
    repeat (2) @(negedge SysClk);
    checks++; if (Data_Out !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", Data_Out); end
    checks++; if (Rx_Error !== 3'b000) begin errors++; $display("FAIL rst_mid_err: got %b expected 000", Rx_Error); end
    checks++; if (Rx_Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", Rx_Busy); end
    Rst = 1'b0;
    repeat (5 * BIT_CYC) @(negedge SysClk);
    checks++; if (q_data.size() !== n0) begin errors++; $display("FAIL rst_mid_strobe: got %0d expected %0d", q_data.size(), n0); end
    checks++; if (Rx_Busy !== 1'b0) begin errors++; $display("FAIL rst_low_line_busy: got %b expected 0", Rx_Busy); end
    drive_bit(1'b1);
    send_frame(8'h12, 1'b0, 2'b11);
    gd = (q_data.size() > n0) ? q_data[n0] : 8'hxx;
    ge = (q_err.size() > n0) ? q_err[n0] : 3'bxxx;
    checks++; if (q_data.size() !== n0 + 1) begin errors++; $display("FAIL post_rst_count: got %0d expected %0d", q_data.size(), n0 + 1); end
    checks++; if (gd !== 8'h12) begin errors++; $display("FAIL post_rst_data: got %h expected 12", gd); end
    checks++; if (ge !== 3'b000) begin errors++; $display("FAIL post_rst_err: got %b expected 000", ge); end
    repeat (100) @(negedge SysClk);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_frame_error();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    checks++; if (max_run !== 1) begin errors++; $display("FAIL rdy_width: got %0d expected 1", max_run); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
